slon5_round_core: RTL and testbench
===================================

SLON5_ROUND_CORE -- requirements
Module: slon5_round_core

Interface
REQ-001 Parameter UNROLL, default 1: number of MD5 steps evaluated per clock; legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_block/in_state valid.
REQ-005 in_ready  output  1  core can accept a block.
REQ-006 in_block  input  512  message block; word M[g] = in_block[32*g +: 32], g = 0..15.
REQ-007 in_state  input  128  chaining value; A = [31:0], B = [63:32], C = [95:64], D = [127:96].
REQ-008 out_valid  output  1  out_digest valid.
REQ-009 out_ready  input  1  consumer accepts out_digest.
REQ-010 out_digest  output  128  updated chaining value; same word packing as in_state.
REQ-011 busy  output  1  high in RUN or DONE.
REQ-012 step_idx  output  6  index of the first step evaluated in the current RUN cycle; 0 outside RUN.

Function
REQ-013 The FSM shall have exactly three states: IDLE, RUN and DONE.
REQ-014 in_ready shall equal (state == IDLE); a transfer occurs on in_valid && in_ready.
REQ-015 On transfer, the core shall latch M[0..15] and in_state (saved copy plus working A/B/C/D), set step counter to 0 and enter RUN.
REQ-016 Each RUN cycle shall apply steps i .. i+UNROLL-1 combinationally in order, then advance the counter by UNROLL.
REQ-017 Step i shall compute F = (B&C)|(~B&D), g = i for i<16; F = (D&B)|(~D&C), g = (5i+1) mod 16 for i<32; F = B^C^D, g = (3i+5) mod 16 for i<48; F = C^(B|~D), g = (7i) mod 16 otherwise.
REQ-018 Step update: tmp = A+F+K[i]+M[g] mod 2^32; A<=D, D<=C, C<=B, B<=B+rotl(tmp, getShift(i)) mod 2^32.
REQ-019 K[i] shall come from the shared KTable_t constant and shift amounts from getShift(); no per-module copies.
REQ-020 After the cycle covering step 63, each word of out_digest shall equal the saved in_state word plus the final A/B/C/D word, mod 2^32; state goes to DONE.
REQ-021 Latency: transfer at cycle t shall give out_valid high from cycle t + 64/UNROLL + 1.
REQ-022 In DONE, out_valid shall be 1 and out_digest held stable until out_ready; on out_valid && out_ready, next state is IDLE.
REQ-023 in_ready shall be 0 in the DONE cycle where out_ready is consumed; a new transfer is possible from the following cycle.
REQ-024 in_valid in RUN or DONE shall be ignored; no inputs are sampled outside the IDLE transfer.
REQ-025 A UNROLL value that is not a legal value shall stop elaboration with $fatal.

Reset
REQ-026 rst shall force IDLE in the next cycle from any state, including mid-RUN, discarding the block.
REQ-027 Reset values shall be: in_ready=1 after release, out_valid=0, busy=0, step_idx=0, out_digest=0; working registers cleared.

Structure
REQ-028 STAGE_NUM, KTable_t, the K constant, getShift() and the 128-bit state and 512-bit block typedefs shall live in slon5_pkg.
REQ-029 One sub-module, slon5_step, shall be the combinational single-step function (step index, A/B/C/D, M in -> A/B/C/D out), instantiated UNROLL times in a generate chain.

Verification
REQ-030 Empty-message padded block (0x80 byte, zero length), IV 67452301/efcdab89/98badcfe/10325476 -> out_digest bytes LSB-first d41d8cd98f00b204e9800998ecf8427e.
REQ-031 "abc" padded block, same IV, UNROLL=1 and UNROLL=4 -> bytes 900150983cd24fb0d6963f7d28e17f72; out_valid at t+65 and t+17 respectively.
REQ-032 out_ready held low 10 cycles in DONE -> out_valid stays 1, out_digest unchanged, in_ready stays 0, second in_valid ignored.
REQ-033 rst pulsed at step_idx=32 -> next cycle IDLE, out_valid=0; then "abc" block yields the correct digest.
REQ-034 Back-to-back blocks with out_ready tied 1 -> one digest per 64/UNROLL+2 cycles, each digest matches the reference model, and the package K constant matches the reference K table at all 64 indices.

Source files
------------

// File: rtl/slon5_pkg.sv
// Shared MD5 round constants, shift schedule and data types for the slon5 round core.
package slon5_pkg;

    localparam int STAGE_NUM = 64;

    typedef logic [127:0] state128_t;
    typedef logic [511:0] block512_t;
    typedef logic [31:0]  KTable_t [0:STAGE_NUM-1];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } coreState_t;

    // Additive constants, one per step.
    localparam KTable_t K = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotate amounts repeat every four steps within each round of sixteen.
    localparam logic [4:0] SHIFT_TAB [0:15] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [4:0] getShift(input logic [5:0] stepIdx);
        return SHIFT_TAB[{stepIdx[5:4], stepIdx[1:0]}];
    endfunction

endpackage

// File: rtl/slon5_step.sv
// One MD5 step as pure combinational logic: (step index, A/B/C/D, block) -> next A/B/C/D.
module slon5_step
    import slon5_pkg::*;
(
    input  logic [5:0]  stepIdx,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  block512_t   block,
    output logic [31:0] aNext,
    output logic [31:0] bNext,
    output logic [31:0] cNext,
    output logic [31:0] dNext
);

    logic [31:0] f;
    logic [3:0]  g;
    logic [31:0] tmp;
    logic [31:0] rotated;
    logic [4:0]  shiftAmt;

    // Pick the round's boolean function and message word index for this step.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path through the case can infer a latch.
        f = 32'h0;
        g = 4'h0;
        unique case (stepIdx[5:4])
            2'd0: begin
                f = (b & c) | (~b & d);
                g = stepIdx[3:0];
            end
            2'd1: begin
                f = (d & b) | (~d & c);
                g = 4'(stepIdx * 6'd5 + 6'd1);
            end
            2'd2: begin
                f = b ^ c ^ d;
                g = 4'(stepIdx * 6'd3 + 6'd5);
            end
            default: begin
                f = c ^ (b | ~d);
                g = 4'(stepIdx * 6'd7);
            end
        endcase
    end

    assign shiftAmt = getShift(stepIdx);
    assign tmp      = a + f + K[stepIdx] + block[{g, 5'd0} +: 32];
    // Shift amounts are never zero, so the right shift never reaches 32.
    assign rotated  = (tmp << shiftAmt) | (tmp >> (6'd32 - {1'b0, shiftAmt}));

    assign aNext = d;
    assign dNext = c;
    assign cNext = b;
    assign bNext = b + rotated;

endmodule

// File: rtl/slon5_round_core.sv
// MD5 compression core: accepts a 512-bit block and chaining value, runs 64 steps
// UNROLL at a time, and offers the updated chaining value until it is taken.
module slon5_round_core
    import slon5_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  block512_t   in_block,
    input  state128_t   in_state,
    output logic        out_valid,
    input  logic        out_ready,
    output state128_t   out_digest,
    output logic        busy,
    output logic [5:0]  step_idx
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : gBadUnroll
        $fatal(1, "slon5_round_core: UNROLL must be 1, 2, 4, 8 or 16");
    end

    localparam logic [5:0] STEP_INC  = 6'(UNROLL);
    localparam logic [5:0] LAST_BASE = 6'(STAGE_NUM - UNROLL);

    coreState_t  state;
    logic [5:0]  stepCnt;
    block512_t   msg;
    state128_t   savedState;
    state128_t   digestReg;
    logic [31:0] workA, workB, workC, workD;
    logic [31:0] finalA, finalB, finalC, finalD;

    // Chain UNROLL single-step instances; each stage feeds the next.
    for (genvar j = 0; j < UNROLL; j++) begin : gStep
        logic [31:0] aIn, bIn, cIn, dIn;
        logic [31:0] aOut, bOut, cOut, dOut;
        if (j == 0) begin : gFirst
            assign aIn = workA;
            assign bIn = workB;
            assign cIn = workC;
            assign dIn = workD;
        end else begin : gNext
            assign aIn = gStep[j-1].aOut;
            assign bIn = gStep[j-1].bOut;
            assign cIn = gStep[j-1].cOut;
            assign dIn = gStep[j-1].dOut;
        end
        slon5_step uStep (
            .stepIdx (stepCnt + 6'(j)),
            .a       (aIn),
            .b       (bIn),
            .c       (cIn),
            .d       (dIn),
            .block   (msg),
            .aNext   (aOut),
            .bNext   (bOut),
            .cNext   (cOut),
            .dNext   (dOut)
        );
    end

    assign finalA = gStep[UNROLL-1].aOut;
    assign finalB = gStep[UNROLL-1].bOut;
    assign finalC = gStep[UNROLL-1].cOut;
    assign finalD = gStep[UNROLL-1].dOut;

    // Handshake, step sequencing and final feed-forward addition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stepCnt    <= '0;
            // NOTE: the block store is a flop register rather than a RAM, so it clears with everything else.
            msg        <= '0;
            savedState <= '0;
            digestReg  <= '0;
            workA      <= '0;
            workB      <= '0;
            workC      <= '0;
            workD      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
                        msg        <= in_block;
                        savedState <= in_state;
                        workA      <= in_state[31:0];
                        workB      <= in_state[63:32];
                        workC      <= in_state[95:64];
                        workD      <= in_state[127:96];
                        stepCnt    <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    workA <= finalA;
                    workB <= finalB;
                    workC <= finalC;
                    workD <= finalD;
                    if (stepCnt == LAST_BASE) begin
                        digestReg <= {savedState[127:96] + finalD,
                                      savedState[95:64]  + finalC,
                                      savedState[63:32]  + finalB,
                                      savedState[31:0]   + finalA};
                        stepCnt   <= '0;
                        state     <= DONE;
                    end else begin
                        stepCnt <= stepCnt + STEP_INC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign step_idx   = (state == RUN) ? stepCnt : 6'd0;
    assign out_digest = digestReg;

endmodule

// File: tb/tb_slon5_round_core.sv
// Bench for slon5_round_core: two instances (UNROLL=1 and UNROLL=4) share inputs and
// are compared every cycle against a transaction-level MD5 model.
module tb_slon5_round_core;

    localparam int NUM_DUT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [511:0] in_block;
    logic [127:0] in_state;

    logic [NUM_DUT-1:0]        inReady;
    logic [NUM_DUT-1:0]        outValid;
    logic [NUM_DUT-1:0]        busyS;
    logic [NUM_DUT-1:0][127:0] outDigest;
    logic [NUM_DUT-1:0][5:0]   stepIdx;

    slon5_round_core #(.UNROLL(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[0]),
        .in_block(in_block), .in_state(in_state), .out_valid(outValid[0]),
        .out_ready(out_ready), .out_digest(outDigest[0]), .busy(busyS[0]),
        .step_idx(stepIdx[0])
    );

    slon5_round_core #(.UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[1]),
        .in_block(in_block), .in_state(in_state), .out_valid(outValid[1]),
        .out_ready(out_ready), .out_digest(outDigest[1]), .busy(busyS[1]),
        .step_idx(stepIdx[1])
    );

    localparam logic [127:0] IV         = 128'h10325476_98badcfe_efcdab89_67452301;
    localparam logic [127:0] DIG_EMPTY  = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
    localparam logic [127:0] DIG_ABC    = 128'h727fe128_7d3f96d6_b04fd23c_98500190;

    int testsRun = 0;
    int testsFailed = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unrollOf(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] kRef [64];
    int sRef [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    function automatic logic [127:0] refMd5(input logic [127:0] iv, input logic [511:0] blk);
        logic [31:0] a, b, c, d, f, t;
        int g, s;
        a = iv[31:0]; b = iv[63:32]; c = iv[95:64]; d = iv[127:96];
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
            s = sRef[(i / 16) * 4 + (i % 4)];
            t = a + f + kRef[i] + blk[32 * g +: 32];
            a = d; d = c; c = b;
            b = b + ((t << s) | (t >> (32 - s)));
        end
        return {iv[127:96] + d, iv[95:64] + c, iv[63:32] + b, iv[31:0] + a};
    endfunction

    // Per-instance transaction view: 0 waiting for a block, 1 computing, 2 offering a digest.
    int           mPhase     [NUM_DUT];
    int           mRunCycles [NUM_DUT];
    logic [127:0] mDigest    [NUM_DUT];
    bit           modelLive = 1'b0;

    // Advance the model on each rising edge from the inputs the DUTs see.
    always @(posedge clk) begin
        for (int k = 0; k < NUM_DUT; k++) begin
            if (rst) begin
                mPhase[k]     <= 0;
                mRunCycles[k] <= 0;
            end else begin
                case (mPhase[k])
                    0: if (in_valid) begin
                        mPhase[k]     <= 1;
                        mRunCycles[k] <= 0;
                        mDigest[k]    <= refMd5(in_state, in_block);
                    end
                    1: begin
                        if (mRunCycles[k] + 1 == 64 / unrollOf(k)) mPhase[k] <= 2;
                        mRunCycles[k] <= mRunCycles[k] + 1;
                    end
                    2: if (out_ready) mPhase[k] <= 0;
                    default: mPhase[k] <= 0;
                endcase
            end
        end
        if (rst) modelLive <= 1'b1;
    end

    // Compare every output of both instances on each falling edge.
    always @(negedge clk) begin
        if (modelLive) begin
            for (int k = 0; k < NUM_DUT; k++) begin
                check($sformatf("in_ready[u%0d]", unrollOf(k)), 128'(inReady[k]), 128'(mPhase[k] == 0));
                check($sformatf("out_valid[u%0d]", unrollOf(k)), 128'(outValid[k]), 128'(mPhase[k] == 2));
                check($sformatf("busy[u%0d]", unrollOf(k)), 128'(busyS[k]), 128'(mPhase[k] != 0));
                check($sformatf("step_idx[u%0d]", unrollOf(k)), 128'(stepIdx[k]),
                      (mPhase[k] == 1) ? 128'(mRunCycles[k] * unrollOf(k)) : 128'd0);
                if (mPhase[k] == 2)
                    check($sformatf("out_digest[u%0d]", unrollOf(k)), outDigest[k], mDigest[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [511:0] blkEmpty, blkAbc;

    task automatic sendBlock(input logic [511:0] blk, input logic [127:0] st);
        in_block = blk;
        in_state = st;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic runBlock(input string name, input logic [511:0] blk, input logic [127:0] expDig);
        bit           seen [NUM_DUT];
        int           cyc  [NUM_DUT];
        logic [127:0] dig  [NUM_DUT];
        int           latLit [NUM_DUT];
        latLit = '{65, 17};
        for (int k = 0; k < NUM_DUT; k++) begin seen[k] = 1'b0; cyc[k] = 0; dig[k] = '0; end
        out_ready = 1'b1;
        sendBlock(blk, IV);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            for (int k = 0; k < NUM_DUT; k++) begin
                if (outValid[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    cyc[k]  = n + 1;
                    dig[k]  = outDigest[k];
                end
            end
            if (seen[0] && seen[1]) break;
        end
        for (int k = 0; k < NUM_DUT; k++) begin
            check($sformatf("%s_timeout[u%0d]", name, unrollOf(k)), 128'(seen[k]), 128'd1);
            check($sformatf("%s_latency[u%0d]", name, unrollOf(k)), 128'(cyc[k]), 128'(latLit[k]));
            check($sformatf("%s_digest[u%0d]", name, unrollOf(k)), dig[k], expDig);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises [NUM_DUT][$];
        bit found;

        for (int i = 0; i < 64; i++) begin
            real s;
            s = $sin(real'(i + 1));
            if (s < 0.0) s = -s;
            kRef[i] = 32'(longint'($floor(s * 4294967296.0)));
        end

        blkEmpty = '0;
        blkEmpty[7:0] = 8'h80;
        blkAbc = '0;
        blkAbc[31:0] = 32'h80636261;
        blkAbc[14*32 +: 32] = 32'd24;

        // Pin the model itself with hand-known values.
        check("kref_0", 128'(kRef[0]), 128'h d76aa478);
        check("kref_63", 128'(kRef[63]), 128'h eb86d391);
        check("model_empty", refMd5(IV, blkEmpty), DIG_EMPTY);
        check("model_abc", refMd5(IV, blkAbc), DIG_ABC);
        for (int i = 0; i < 64; i++)
            check($sformatf("pkg_K[%0d]", i), 128'(slon5_pkg::K[i]), 128'(kRef[i]));

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_block = '0; in_state = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NUM_DUT; k++) begin
            check($sformatf("rst_in_ready[u%0d]", unrollOf(k)), 128'(inReady[k]), 128'd1);
            check($sformatf("rst_out_valid[u%0d]", unrollOf(k)), 128'(outValid[k]), 128'd0);
            check($sformatf("rst_busy[u%0d]", unrollOf(k)), 128'(busyS[k]), 128'd0);
            check($sformatf("rst_step_idx[u%0d]", unrollOf(k)), 128'(stepIdx[k]), 128'd0);
            check($sformatf("rst_digest[u%0d]", unrollOf(k)), outDigest[k], 128'd0);
        end

        runBlock("empty", blkEmpty, DIG_EMPTY);
        runBlock("abc", blkAbc, DIG_ABC);

        // Consumer stalls: digest must hold and further blocks must be refused.
        out_ready = 1'b0;
        sendBlock(blkAbc, IV);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            found = outValid[0];
        end
        check("hold_wait", 128'(found), 128'd1);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_block = blkEmpty;
            @(negedge clk);
            for (int k = 0; k < NUM_DUT; k++) begin
                check($sformatf("hold_valid[u%0d]", unrollOf(k)), 128'(outValid[k]), 128'd1);
                check($sformatf("hold_digest[u%0d]", unrollOf(k)), outDigest[k], DIG_ABC);
                check($sformatf("hold_in_ready[u%0d]", unrollOf(k)), 128'(inReady[k]), 128'd0);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NUM_DUT; k++)
            check($sformatf("release_in_ready[u%0d]", unrollOf(k)), 128'(inReady[k]), 128'd1);

        // Reset in the middle of a block.
        sendBlock(blkAbc, IV);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            if (stepIdx[0] == 6'd32) found = 1'b1;
            else @(negedge clk);
        end
        check("midrst_reach32", 128'(found), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 128'(inReady[0]), 128'd1);
        check("midrst_out_valid", 128'(outValid[0]), 128'd0);
        check("midrst_busy", 128'(busyS[0]), 128'd0);
        check("midrst_step_idx", 128'(stepIdx[0]), 128'd0);
        runBlock("abc_after_rst", blkAbc, DIG_ABC);

        // Back-to-back blocks with the consumer always ready.
        out_ready = 1'b1;
        for (int n = 0; n < 3 * 66 + 4; n++) begin
            for (int w = 0; w < 16; w++)
                in_block[32 * w +: 32] = 32'(n * 16 + w) * 32'h9e3779b9;
            in_state = {32'(n) ^ 32'h10325476, 32'(n) + 32'h98badcfe,
                        32'(n) * 32'h01000193, 32'(n) ^ 32'h67452301};
            in_valid = 1'b1;
            @(negedge clk);
            for (int k = 0; k < NUM_DUT; k++)
                if (outValid[k]) rises[k].push_back(n);
        end
        in_valid = 1'b0;
        repeat (70) @(negedge clk);
        for (int k = 0; k < NUM_DUT; k++) begin
            check($sformatf("b2b_count[u%0d]", unrollOf(k)), 128'(rises[k].size() >= 3), 128'd1);
            for (int i = 1; i < rises[k].size(); i++)
                check($sformatf("b2b_period[u%0d]", unrollOf(k)),
                      128'(rises[k][i] - rises[k][i-1]), 128'(64 / unrollOf(k) + 2));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
